// File: rtl/wb_uart_tx_master.sv
// Wishbone classic initiator that feeds a byte stream into an 8250-style UART (LSR poll, then THR write).
// Define WB_UART_TX_MASTER_POLL_EN to poll LSR.THRE before each write; otherwise bytes go straight to THR.
module wb_uart_tx_master #(
  parameter logic [31:0] UART_BASE = 32'h1250_0000,
  parameter logic [15:0] TIMEOUT   = 16'd255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic        ACK_I,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        err_clr,
  output logic        err,
  output logic        busy
);

  localparam logic [31:0] LSR_ADR = UART_BASE + 32'd5;
  localparam logic [31:0] THR_ADR = UART_BASE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POLL  = 3'd1,
    GAP_P = 3'd2,
    GAP_W = 3'd3,
    WRITE = 3'd4,
    GAP_I = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  byte_q;
  logic [7:0]  wr_byte;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        accept, acked, timed_out;
  logic        unused_dat;

  assign accept    = tx_valid && ready_q;
  assign acked     = stb_q && ACK_I;
  assign timed_out = stb_q && !ACK_I && (tmo_cnt_q == TIMEOUT - 16'd1);

`ifdef WB_UART_TX_MASTER_POLL_EN
  assign unused_dat = ^{DAT_I[31:6], DAT_I[4:0]};
`else
  assign unused_dat = ^DAT_I;
`endif

  // State register
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef WB_UART_TX_MASTER_POLL_EN
        if (accept) state_d = POLL;
`else
        if (accept) state_d = WRITE;
`endif
      end
`ifdef WB_UART_TX_MASTER_POLL_EN
      POLL: begin
        if (timed_out)  state_d = GAP_I;
        else if (acked) state_d = DAT_I[5] ? GAP_W : GAP_P;
      end
      GAP_P: state_d = POLL;
      GAP_W: state_d = WRITE;
`endif
      WRITE: begin
        if (timed_out || acked) state_d = GAP_I;
      end
      GAP_I:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values, derived from the state being entered
  always_comb begin
    wr_byte = (state_q == IDLE) ? tx_data : byte_q;
    stb_d   = (state_d == POLL) || (state_d == WRITE);
    we_d    = (state_d == WRITE);
    adr_d   = 32'd0;
    dat_d   = 32'd0;
    if (state_d == POLL) begin
      adr_d = LSR_ADR;
    end else if (state_d == WRITE) begin
      adr_d = THR_ADR;
      dat_d = {24'd0, wr_byte};
    end
    ready_d   = (state_d == IDLE);
    tmo_cnt_d = (stb_q && !ACK_I && !timed_out) ? tmo_cnt_q + 16'd1 : 16'd0;
    err_d     = timed_out ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 32'd0;
      dat_q     <= 32'd0;
      ready_q   <= 1'b0;
      tmo_cnt_q <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      ready_q   <= ready_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  // Byte holding register is pure data and needs no reset
  always_ff @(posedge CLK_I) begin
    if (accept) byte_q <= tx_data;
  end

  assign STB_O    = stb_q;
  assign CYC_O    = stb_q;
  assign SEL_O    = {3'b000, stb_q};
  assign WE_O     = we_q;
  assign ADR_O    = adr_q;
  assign DAT_O    = dat_q;
  assign tx_ready = ready_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule
